// File: rtl/tap_scan_sequencer.sv
// Host-side JTAG scan engine: turns IR/DR/reset commands into TMS/TDI walks
// that start and end in Run-Test/Idle, capturing TDO into the response.
module tap_scan_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tclk,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_reset,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int CNT_W = LEN_W + 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {RST_SEQ, IDLE, PRE, SHIFT, POST, ERR} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   len_q, len_n;
  logic               ir_q, ir_n;
  logic               rcmd_q, rcmd_n;
  logic [MAX_LEN-1:0] sh_q, sh_n;
  logic [MAX_LEN-1:0] cap_q, cap_n;
  logic [MAX_LEN-1:0] rsp_data_n;
  logic               tms_n, tdi_n, rsp_valid_n, rsp_err_n;
  logic [CNT_W-1:0]   cmd_len_x;
  logic [CNT_W-1:0]   pre_last;
  logic               len_bad;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmd_len_x = CNT_W'(cmd_len);
  assign len_bad   = (cmd_len_x == '0) || (cmd_len_x > CNT_W'(MAX_LEN));
  // IR walk visits Select-IR, so its preamble is one element longer
  assign pre_last  = ir_q ? CNT_W'(3) : CNT_W'(2);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    len_n       = len_q;
    ir_n        = ir_q;
    rcmd_n      = rcmd_q;
    sh_n        = sh_q;
    cap_n       = cap_q;
    rsp_data_n  = rsp_data;
    tms_n       = 1'b0;
    tdi_n       = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    case (state)
      RST_SEQ: begin
        if (cnt < CNT_W'(4)) begin
          cnt_n = cnt + CNT_W'(1);
          tms_n = 1'b1;
        end else if (cnt == CNT_W'(4)) begin
          cnt_n = CNT_W'(5);
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
          rcmd_n  = 1'b0;
          if (rcmd_q) begin
            rsp_valid_n = 1'b1;
            rsp_data_n  = '0;
          end
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          cnt_n = '0;
          if (cmd_reset) begin
            state_n = RST_SEQ;
            rcmd_n  = 1'b1;
            tms_n   = 1'b1;
          end else if (len_bad) begin
            state_n = ERR;
          end else begin
            state_n = PRE;
            len_n   = cmd_len_x;
            ir_n    = cmd_ir;
            sh_n    = cmd_data;
            cap_n   = '0;
            tms_n   = 1'b1;
          end
        end
      end
      PRE: begin
        if (cnt < pre_last) begin
          cnt_n = cnt + CNT_W'(1);
          tms_n = ir_q && (cnt == '0);
        end else begin
          state_n = SHIFT;
          cnt_n   = '0;
          tms_n   = (len_q == CNT_W'(1));
          tdi_n   = sh_q[0];
          sh_n    = sh_q >> 1;
        end
      end
      SHIFT: begin
        cap_n[cnt[IDX_W-1:0]] = tdo;
        if ((cnt + CNT_W'(1)) < len_q) begin
          cnt_n = cnt + CNT_W'(1);
          tms_n = ((cnt + CNT_W'(2)) == len_q);
          tdi_n = sh_q[0];
          sh_n  = sh_q >> 1;
        end else begin
          state_n = POST;
          cnt_n   = '0;
          tms_n   = 1'b1;
        end
      end
      POST: begin
        if (cnt == '0) begin
          cnt_n = CNT_W'(1);
        end else begin
          state_n     = IDLE;
          cnt_n       = '0;
          rsp_valid_n = 1'b1;
          rsp_data_n  = cap_q;
        end
      end
      ERR: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b1;
        rsp_err_n   = 1'b1;
        rsp_data_n  = '0;
      end
      default: begin
        state_n = RST_SEQ;
        cnt_n   = '0;
        tms_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge tclk) begin
    if (!trst) begin
      state     <= RST_SEQ;
      cnt       <= '0;
      rcmd_q    <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rcmd_q    <= rcmd_n;
      tms       <= tms_n;
      tdi       <= tdi_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_data  <= rsp_data_n;
    end
  end

  // command operands and capture buffer are only read inside a running scan
  always_ff @(posedge tclk) begin
    len_q <= len_n;
    ir_q  <= ir_n;
    sh_q  <= sh_n;
    cap_q <= cap_n;
  end

endmodule

// File: tb/tb_tap_scan_sequencer.sv
// Scoreboard bench for tap_scan_sequencer: a command-level model predicts
// the per-cycle TMS/TDI walk, the TDO to present, and the response.
module tb_tap_scan_sequencer;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic              tclk = 1'b0;
  logic              trst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_reset = 1'b0;
  logic              cmd_ir = 1'b0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic              rsp_valid, rsp_err, busy, tms, tdi;
  logic [MAX_LEN-1:0] rsp_data;
  logic              tdo = 1'b0;

  tap_scan_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tclk(tclk), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reset(cmd_reset), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
    .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 tclk = ~tclk;

  typedef struct { int cyc; bit tms; bit tdi; bit tdo; } step_t;
  typedef struct { int cyc; bit err; logic [31:0] data; } rsp_t;

  step_t tq[$];
  rsp_t  rq[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    walk_en = 1'b0;
  int    last_rsp_cyc = 0;

  always @(posedge tclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle monitor: TMS/TDI walk, TDO presentation, and responses.
  initial begin
    forever begin
      @(negedge tclk);
      if (walk_en) begin
        if (tq.size() > 0 && tq[0].cyc == cyc) begin
          chk("tms", {31'd0, tms}, {31'd0, tq[0].tms});
          chk("tdi", {31'd0, tdi}, {31'd0, tq[0].tdi});
          chk("busy_walk", {31'd0, busy}, 32'd1);
          tdo = tq[0].tdo;
          void'(tq.pop_front());
        end else begin
          chk("tms_idle", {31'd0, tms}, 32'd0);
          chk("tdi_idle", {31'd0, tdi}, 32'd0);
          tdo = 1'b0;
        end
      end
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        chk("rsp_missing", 32'd0, 32'd1);
        void'(rq.pop_front());
      end
      if (rsp_valid === 1'b1) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          chk("rsp_cycle", cyc, rq[0].cyc);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, rq[0].err});
          chk("rsp_data", rsp_data, rq[0].data);
          chk("rsp_ready", {31'd0, cmd_ready}, 32'd1);
          chk("rsp_busy", {31'd0, busy}, 32'd0);
          void'(rq.pop_front());
        end
      end
    end
  end

  // Reference model + driver: one call = one accepted command.
  // mode: 0 tdo held low, 1 tdo loops tdi back, 2 random tdo.
  task automatic issue(input bit rst, input bit ir, input int len,
                       input logic [31:0] data, input int mode, input bit b2b);
    bit s_tms[$];
    bit s_tdi[$];
    bit s_tdo[$];
    bit b;
    logic [31:0] exp_data = '0;
    bit err = 1'b0;
    int lat;
    int c;
    int waitc = 0;
    if (rst) begin
      s_tms = '{1, 1, 1, 1, 1, 0};
      for (int k = 0; k < 6; k++) begin s_tdi.push_back(0); s_tdo.push_back(0); end
      lat = 6;
    end else if (len == 0 || len > MAX_LEN) begin
      err = 1'b1;
      lat = 1;
    end else begin
      if (ir) s_tms = '{1, 1, 0, 0}; else s_tms = '{1, 0, 0};
      for (int k = 0; k < s_tms.size(); k++) begin s_tdi.push_back(0); s_tdo.push_back(0); end
      for (int i = 0; i < len; i++) begin
        b = (mode == 1) ? data[i] : (mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
        exp_data[i] = b;
        s_tms.push_back(i == len - 1);
        s_tdi.push_back(data[i]);
        s_tdo.push_back(b);
      end
      s_tms.push_back(1); s_tdi.push_back(0); s_tdo.push_back(0);
      s_tms.push_back(0); s_tdi.push_back(0); s_tdo.push_back(0);
      lat = s_tms.size();
    end
    cmd_valid = 1'b1;
    cmd_reset = rst;
    cmd_ir    = ir;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    while (cmd_ready !== 1'b1 && waitc < 200) begin
      @(posedge tclk); #1;
      waitc++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (b2b) chk("held_accept_cycle", cyc, last_rsp_cyc);
    c = cyc + 1;
    for (int k = 0; k < s_tms.size(); k++)
      tq.push_back('{cyc: c + k, tms: s_tms[k], tdi: s_tdi[k], tdo: s_tdo[k]});
    rq.push_back('{cyc: c + lat, err: err, data: exp_data});
    last_rsp_cyc = c + lat;
    @(posedge tclk); #1;
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
  endtask

  task automatic do_reset(input int nlow);
    int r;
    trst = 1'b0;
    walk_en = 1'b0;
    tq.delete();
    rq.delete();
    repeat (nlow) begin
      @(posedge tclk); #1;
      chk("rst_tms", {31'd0, tms}, 32'd1);
      chk("rst_tdi", {31'd0, tdi}, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
    end
    trst = 1'b1;
    r = cyc;
    for (int k = 0; k < 6; k++)
      tq.push_back('{cyc: r + k, tms: (k < 5), tdi: 0, tdo: 0});
    walk_en = 1'b1;
    repeat (5) begin @(posedge tclk); #1; end
    chk("walk_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(posedge tclk); #1;
    chk("walk_ready_high", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int len, sel, waitc;
    #1;
    do_reset(3);

    issue(0, 0, 8, 32'h0000_00A5, 1, 0);
    issue(0, 1, 1, 32'h1, 0, 0);
    issue(0, 0, 0, 32'h1234, 1, 0);
    issue(0, 0, 33, 32'h1234, 1, 0);
    issue(0, 0, 32, 32'hDEAD_BEEF, 1, 0);
    issue(0, 1, 5, 32'h1F, 2, 1);
    issue(1, 0, 7, 32'hFFFF, 1, 1);
    issue(0, 0, 63, 32'h0, 1, 1);
    issue(0, 1, 32, 32'h8000_0001, 2, 0);

    issue(0, 0, 16, 32'h0000_C3A5, 1, 0);
    repeat (6) begin @(posedge tclk); #1; end
    do_reset(2);
    issue(0, 0, 12, 32'h0000_0ABC, 1, 0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, MAX_LEN);
      if (sel == 0) issue(1, $urandom_range(0, 1), len, $urandom, 1, 0);
      else if (sel == 1) issue(0, $urandom_range(0, 1),
                               ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(33, 63), $urandom, 1, 0);
      else issue(0, $urandom_range(0, 1), len, $urandom, $urandom_range(0, 2),
                 $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) begin @(posedge tclk); #1; end
    end

    waitc = 0;
    while ((rq.size() > 0 || tq.size() > 0) && waitc < 200) begin
      @(posedge tclk); #1;
      waitc++;
    end
    chk("drain", rq.size() + tq.size(), 32'd0);
    repeat (3) begin @(posedge tclk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tap_scan_sequencer.md
Name: tap_scan_sequencer

Overview:
- Host-side JTAG scan engine. Drives TMS/TDI into a downstream TAP controller, one bit per tclk, and captures TDO.
- Converts single commands into TMS walks that end in Run-Test/Idle: IR scan, DR scan, or forced Test-Logic-Reset.
- Shifted-in TDO bits are returned on a response port.
- Sits between a register-level host interface and the 16-state TAP, and parks the TAP in Run-Test/Idle between commands.

Parameters:
- MAX_LEN, 32, maximum scan length in bits; also the width of the data buses.
- LEN_W, 6, width of cmd_len; must hold the value MAX_LEN.

Ports:
- tclk  in  1  scan clock; all logic on posedge.
- trst  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on posedge when cmd_valid && cmd_ready.
- cmd_reset  in  1  1 = drive TAP to Test-Logic-Reset, then Run-Test/Idle. Takes priority over cmd_ir; len and data are ignored.
- cmd_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  LEN_W  number of shift bits.
- cmd_data  in  MAX_LEN  TDI data, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse at command completion.
- rsp_err  out  1  valid with rsp_valid; illegal length.
- rsp_data  out  MAX_LEN  captured TDO; bit i = i-th shifted bit; bits >= len are 0.
- busy  out  1  high whenever not in IDLE.
- tms  out  1  registered TMS to TAP.
- tdi  out  1  registered TDI to TAP.
- tdo  in  1  TDO from target.

Behaviour:
- Timing model:
  - tms/tdi are registered; a value driven after edge k is consumed by the TAP at edge k+1.
  - One such period is one "scan cycle".
- Reset (trst=0 at a posedge) forces:
  - state=RST_SEQ, tms=1, tdi=0, cmd_ready=0, busy=1.
  - rsp_valid=0, rsp_err=0, rsp_data=0; internal bit counter=0.
  - Reset aborts any scan in progress immediately, with no rsp_valid.
- RST_SEQ:
  - After trst returns high, drive tms=1 for 5 scan cycles, then tms=0 for 1 cycle (TAP reaches Run-Test/Idle).
  - Then go to IDLE.
- IDLE:
  - tms=0, tdi=0, cmd_ready=1, busy=0.
  - rsp_data holds the last result until the next rsp_valid.
- Command acceptance (at edge E0, cmd_valid && cmd_ready): cmd_ready drops the same edge. Then by command type:
  - cmd_reset=1: runs the RST_SEQ walk (5 ones, then a zero). rsp_valid at E0+6, rsp_err=0, rsp_data=0.
  - len==0 or len>MAX_LEN (no reset): no TMS activity. rsp_valid and rsp_err=1 at E0+1, rsp_data=0.
  - DR scan, TMS sequence: 1 (SelDR), 0 (CapDR), 0 (ShiftDR), then len shift cycles, then 1 (UpdDR), 0 (RTI). N = len+5.
  - IR scan, TMS sequence: 1, 1 (SelIR), 0 (CapIR), 0 (ShiftIR), then len shift cycles, then 1 (UpdIR), 0 (RTI). N = len+6.
- Shift cycles:
  - Cycle i (0..len-1): tdi = cmd_data[i] (data latched at E0); tms = 0 except tms=1 on i = len-1 (-> Exit1).
  - tdo is sampled at the edge ending shift cycle i into rsp_data[i].
  - tdi = 0 outside shift cycles.
- Completion:
  - Scan: state returns to IDLE at edge E0+N.
  - rsp_valid=1 for exactly one cycle. cmd_ready=1 in that same cycle, so back-to-back commands are allowed.
- Pause states are never entered. The sequencer assumes exclusive ownership of the TAP.
- States: RST_SEQ, IDLE, PRE (select/capture walk), SHIFT, POST (update, RTI), ERR.
- Counter: LEN_W+1 bits; no wrap at len=MAX_LEN.
- busy: high from E0 until the rsp_valid cycle, exclusive.

Test Plan:
- trst low 3 cycles, then high -> tms = 1,1,1,1,1,0; cmd_ready rises after the 6th cycle; rsp_valid never pulses.
- DR scan, len=8, data=0xA5, tdo looped to tdi:
  - tms = 1,0,0,0000000 then 1, then 1,0.
  - tdi shift bits 1,0,1,0,0,1,0,1.
  - rsp_valid at E0+13, rsp_data=0x000000A5, rsp_err=0.
- IR scan, len=1, data=1, tdo=0 -> tms = 1,1,0,0,1,1,0; rsp_valid at E0+7; rsp_data=0.
- len=0, then len=33 -> each gives rsp_valid at E0+1, rsp_err=1, no tms pulse; cmd_ready low only for the one cycle.
- DR scan, len=32, data=0xDEADBEEF, loopback -> rsp_data=0xDEADBEEF at E0+37. A cmd_valid held during busy is not accepted until the rsp_valid cycle.
- trst low during shift cycle 3 of a len=16 scan -> no rsp_valid; outputs reset; RST_SEQ walk replays; next DR scan completes correctly.
